// File: rtl/regn_pkg.sv
// Shared definitions for the universal register: mode encodings and width bounds.
package regn_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_INC  = 3'b110,
    OP_DEC  = 3'b111
  } mode_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/regn_univ_if.sv
// Control/data bundle of the universal register.
// master drives operation and data; slave returns contents and flags.
interface regn_univ_if #(
  parameter int WIDTH = 8
);
  logic             EN;
  logic [2:0]       Mode;
  logic [WIDTH-1:0] Reg_In;
  logic             Ser_In;
  logic [WIDTH-1:0] Reg_Out;
  logic             Cout;
  logic             Zero;

  modport master (
    output EN, Mode, Reg_In, Ser_In,
    input  Reg_Out, Cout, Zero
  );

  modport slave (
    input  EN, Mode, Reg_In, Ser_In,
    output Reg_Out, Cout, Zero
  );
endinterface

// File: rtl/regn_next.sv
// Next-state function of the universal register: value and carry per mode.
// Purely combinational; no backpressure.
module regn_next
  import regn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] old_value,
  input  logic             old_cout,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] reg_in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] next_value,
  output logic             next_cout
);

  always_comb begin
    next_value = old_value;
    next_cout  = old_cout;
    case (mode)
      MODE_HOLD: begin
        next_value = old_value;
        next_cout  = old_cout;
      end
      MODE_LOAD: begin
        next_value = reg_in;
        next_cout  = 1'b0;
      end
      MODE_SHL: begin
        next_value = {old_value[WIDTH-2:0], ser_in};
        next_cout  = old_value[WIDTH-1];
      end
      MODE_SHR: begin
        next_value = {ser_in, old_value[WIDTH-1:1]};
        next_cout  = old_value[0];
      end
      MODE_ROL: begin
        next_value = {old_value[WIDTH-2:0], old_value[WIDTH-1]};
        next_cout  = old_value[WIDTH-1];
      end
      MODE_ROR: begin
        next_value = {old_value[0], old_value[WIDTH-1:1]};
        next_cout  = old_value[0];
      end
      // The extra top bit of the widened sum/difference is the carry/borrow.
      MODE_INC: {next_cout, next_value} = {1'b0, old_value} + {{WIDTH{1'b0}}, 1'b1};
      MODE_DEC: {next_cout, next_value} = {1'b0, old_value} - {{WIDTH{1'b0}}, 1'b1};
      default: begin
        next_value = old_value;
        next_cout  = old_cout;
      end
    endcase
  end

endmodule

// File: rtl/regn_univ.sv
// Universal register (hold/load/shift/rotate/inc/dec) with carry and zero flags.
// Latency 1 cycle; accepts an operation every cycle, EN=0 holds.
module regn_univ
  import regn_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic        clk,
  input logic        res,
  regn_univ_if.slave bus
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("regn_univ: WIDTH must be within 2..32");
  end

  logic [WIDTH:0]   state_q;
  logic [WIDTH-1:0] next_value;
  logic             next_cout;

  regn_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .old_value (state_q[WIDTH-1:0]),
    .old_cout  (state_q[WIDTH]),
    .mode      (bus.Mode),
    .reg_in    (bus.Reg_In),
    .ser_in    (bus.Ser_In),
    .next_value(next_value),
    .next_cout (next_cout)
  );

  // Carry lives in the top bit so value and flag update as one stage.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= {1'b0, RESET_VAL};
    end else if (bus.EN) begin
      state_q <= {next_cout, next_value};
    end
  end

  assign bus.Reg_Out = state_q[WIDTH-1:0];
  assign bus.Cout    = state_q[WIDTH];
  assign bus.Zero    = (state_q[WIDTH-1:0] == '0);

  a_mode_known : assert property (@(posedge clk) disable iff (res) bus.EN |-> !$isunknown(bus.Mode));

endmodule

// File: tb/tb_regn_univ.sv
// Bench for regn_univ: directed table on an 8-bit instance, then random
// operation streams on widths 8, 8 (reset 0x5A), 2, 13 and 32 against a reference model.
module tb_regn_univ;
  import regn_pkg::*;

  localparam int N = 5;

  logic        clk = 1'b0;
  logic        res;
  logic        en;
  logic [2:0]  mode;
  logic [31:0] din;
  logic        ser;

  always #5 clk = ~clk;

  regn_univ_if #(.WIDTH(8))  if_a ();
  regn_univ_if #(.WIDTH(8))  if_b ();
  regn_univ_if #(.WIDTH(2))  if_c ();
  regn_univ_if #(.WIDTH(13)) if_d ();
  regn_univ_if #(.WIDTH(32)) if_e ();

  assign if_a.EN = en;  assign if_a.Mode = mode;  assign if_a.Reg_In = din[7:0];   assign if_a.Ser_In = ser;
  assign if_b.EN = en;  assign if_b.Mode = mode;  assign if_b.Reg_In = din[7:0];   assign if_b.Ser_In = ser;
  assign if_c.EN = en;  assign if_c.Mode = mode;  assign if_c.Reg_In = din[1:0];   assign if_c.Ser_In = ser;
  assign if_d.EN = en;  assign if_d.Mode = mode;  assign if_d.Reg_In = din[12:0];  assign if_d.Ser_In = ser;
  assign if_e.EN = en;  assign if_e.Mode = mode;  assign if_e.Reg_In = din;        assign if_e.Ser_In = ser;

  regn_univ #(.WIDTH(8),  .RESET_VAL(8'h00))  u_a (.clk(clk), .res(res), .bus(if_a.slave));
  regn_univ #(.WIDTH(8),  .RESET_VAL(8'h5A))  u_b (.clk(clk), .res(res), .bus(if_b.slave));
  regn_univ #(.WIDTH(2),  .RESET_VAL(2'b00))  u_c (.clk(clk), .res(res), .bus(if_c.slave));
  regn_univ #(.WIDTH(13), .RESET_VAL(13'h0))  u_d (.clk(clk), .res(res), .bus(if_d.slave));
  regn_univ #(.WIDTH(32), .RESET_VAL(32'h0))  u_e (.clk(clk), .res(res), .bus(if_e.slave));

  logic [31:0] dout [N];
  logic        dc   [N];
  logic        dz   [N];

  assign dout[0] = {24'b0, if_a.Reg_Out};  assign dc[0] = if_a.Cout;  assign dz[0] = if_a.Zero;
  assign dout[1] = {24'b0, if_b.Reg_Out};  assign dc[1] = if_b.Cout;  assign dz[1] = if_b.Zero;
  assign dout[2] = {30'b0, if_c.Reg_Out};  assign dc[2] = if_c.Cout;  assign dz[2] = if_c.Zero;
  assign dout[3] = {19'b0, if_d.Reg_Out};  assign dc[3] = if_d.Cout;  assign dz[3] = if_d.Zero;
  assign dout[4] = if_e.Reg_Out;           assign dc[4] = if_e.Cout;  assign dz[4] = if_e.Zero;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] mv [N];
  logic        mc [N];

  function automatic int wid(input int k);
    case (k)
      0, 1:    return 8;
      2:       return 2;
      3:       return 13;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] rst_of(input int k);
    return (k == 1) ? 32'h5A : 32'h0;
  endfunction

  // Reference behaviour in plain unsigned arithmetic modulo 2^w.
  function automatic logic [32:0] model_step(input int w, input logic [31:0] old, input logic oc,
                                             input logic [2:0] m, input logic [31:0] d, input logic s);
    longint modv, o, v, top;
    logic c;
    modv = longint'(1) << w;
    o    = longint'(old);
    top  = (o >> (w - 1)) & 1;
    v = o;
    c = oc;
    case (m)
      MODE_LOAD: begin v = longint'(d) % modv;                     c = 1'b0;       end
      MODE_SHL:  begin v = (o * 2 + longint'(s)) % modv;           c = (top != 0); end
      MODE_SHR:  begin v = o / 2 + longint'(s) * (modv / 2);       c = (o % 2 != 0); end
      MODE_ROL:  begin v = (o * 2 + top) % modv;                   c = (top != 0); end
      MODE_ROR:  begin v = o / 2 + (o % 2) * (modv / 2);           c = (o % 2 != 0); end
      MODE_INC:  begin v = (o + 1) % modv;                         c = (o == modv - 1); end
      MODE_DEC:  begin v = (o + modv - 1) % modv;                  c = (o == 0);   end
      default:   begin v = o;                                      c = oc;         end
    endcase
    return {c, v[31:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one operation, advance one edge, update the model and compare every instance.
  task automatic tick(input logic r, input logic e, input logic [2:0] m,
                      input logic [31:0] d, input logic s);
    logic [32:0] nx;
    res = r; en = e; mode = m; din = d; ser = s;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (r) begin
        mv[k] = rst_of(k);
        mc[k] = 1'b0;
      end else if (e) begin
        nx = model_step(wid(k), mv[k], mc[k], m, d, s);
        mv[k] = nx[31:0];
        mc[k] = nx[32];
      end
      check($sformatf("w%0d_i%0d_out", wid(k), k), dout[k], mv[k]);
      check($sformatf("w%0d_i%0d_cout", wid(k), k), {31'b0, dc[k]}, {31'b0, mc[k]});
      check($sformatf("w%0d_i%0d_zero", wid(k), k), {31'b0, dz[k]}, {31'b0, (mv[k] == 32'h0)});
    end
  endtask

  typedef struct {
    logic       r;
    logic       e;
    logic [2:0] m;
    logic [7:0] d;
    logic       s;
    logic [7:0] q;
    logic       c;
    logic       z;
  } vec_t;

  vec_t vt[$];

  initial begin
    res = 1'b1; en = 1'b0; mode = MODE_HOLD; din = '0; ser = 1'b0;

    //                r  e  mode       din    s  q      c  z
    vt.push_back('{1, 1, MODE_LOAD, 8'hFF, 0, 8'h00, 0, 1});
    vt.push_back('{0, 1, MODE_LOAD, 8'hA5, 0, 8'hA5, 0, 0});
    vt.push_back('{0, 0, MODE_INC,  8'h00, 0, 8'hA5, 0, 0});
    vt.push_back('{0, 0, MODE_INC,  8'h00, 0, 8'hA5, 0, 0});
    vt.push_back('{0, 0, MODE_INC,  8'h00, 0, 8'hA5, 0, 0});
    vt.push_back('{0, 1, MODE_HOLD, 8'h00, 0, 8'hA5, 0, 0});
    vt.push_back('{0, 1, MODE_LOAD, 8'h81, 1, 8'h81, 0, 0});
    vt.push_back('{0, 1, MODE_SHL,  8'h00, 0, 8'h02, 1, 0});
    vt.push_back('{0, 1, MODE_SHR,  8'h00, 1, 8'h81, 0, 0});
    vt.push_back('{0, 1, MODE_ROR,  8'h00, 0, 8'hC0, 1, 0});
    vt.push_back('{0, 1, MODE_ROL,  8'h00, 0, 8'h81, 1, 0});
    vt.push_back('{0, 1, MODE_LOAD, 8'hFE, 0, 8'hFE, 0, 0});
    vt.push_back('{0, 1, MODE_INC,  8'h00, 0, 8'hFF, 0, 0});
    vt.push_back('{0, 1, MODE_INC,  8'h00, 0, 8'h00, 1, 1});
    vt.push_back('{0, 1, MODE_DEC,  8'h00, 0, 8'hFF, 1, 0});
    vt.push_back('{0, 1, MODE_HOLD, 8'h00, 1, 8'hFF, 1, 0});
    vt.push_back('{0, 0, 3'bxxx,    8'h00, 1, 8'hFF, 1, 0});
    vt.push_back('{0, 1, MODE_DEC,  8'h00, 0, 8'hFE, 0, 0});
    vt.push_back('{0, 1, MODE_LOAD, 8'h10, 0, 8'h10, 0, 0});
    vt.push_back('{0, 1, MODE_INC,  8'h00, 0, 8'h11, 0, 0});
    vt.push_back('{0, 1, MODE_INC,  8'h00, 0, 8'h12, 0, 0});
    vt.push_back('{1, 1, MODE_INC,  8'h00, 0, 8'h00, 0, 1});
    vt.push_back('{0, 1, MODE_INC,  8'h00, 0, 8'h01, 0, 0});

    @(negedge clk);
    for (int i = 0; i < vt.size(); i++) begin
      tick(vt[i].r, vt[i].e, vt[i].m, {24'b0, vt[i].d}, vt[i].s);
      check($sformatf("vec%0d_out", i), dout[0], {24'b0, vt[i].q});
      check($sformatf("vec%0d_cout", i), {31'b0, dc[0]}, {31'b0, vt[i].c});
      check($sformatf("vec%0d_zero", i), {31'b0, dz[0]}, {31'b0, vt[i].z});
      if (i == 0) check("reset_val_5a", dout[1], 32'h5A);
    end

    // Width sweep: all-ones load followed by INC wraps every width to zero with carry.
    tick(1'b0, 1'b1, MODE_LOAD, 32'hFFFF_FFFF, 1'b0);
    tick(1'b0, 1'b1, MODE_INC, 32'h0, 1'b0);
    for (int k = 0; k < N; k++) begin
      check($sformatf("wrap_w%0d_i%0d_out", wid(k), k), dout[k], 32'h0);
      check($sformatf("wrap_w%0d_i%0d_cout", wid(k), k), {31'b0, dc[k]}, 32'h1);
    end

    // Eight SHL edges fully replace an 8-bit value with the serial stream.
    tick(1'b0, 1'b1, MODE_LOAD, 32'h0000_00C3, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, MODE_SHL, 32'h0, ((8'h5B >> (7 - i)) & 8'h1) != 0);
    check("shl8_replace", dout[0], 32'h5B);

    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
           3'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
